bc_mac_seq: RTL and testbench
=============================

# bc_mac_seq

Parametrised bit-column MAC engine: computes the dot product of LANES unsigned activations with LANES multi-bit weights by streaming one weight bit-plane per cycle through a bit-column AND/compressor reduction and a shift-accumulate register. It succeeds the fixed 8-lane, 4-bit, single-bit-plane slice with a self-sequencing FSM, valid/ready handshakes and multi-vector accumulation. It sits between the activation/weight buffers and the output requantiser of a PE column.

## Interface
- LANES, 8, number of activation/weight pairs per vector
- ABITS, 4, activation width (unsigned)
- WBITS, 8, weight width; also the number of bit-plane cycles per vector
- ACCW, 24, accumulator/result width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  vector offered
- in_ready  out  1  engine can accept a vector
- in_first  in  1  clear accumulator before this vector
- in_last  in  1  emit result after this vector
- act  in  LANES*ABITS  lane i at act[i*ABITS +: ABITS]
- weight  in  LANES*WBITS  lane i at weight[i*WBITS +: WBITS]
- out_valid  out  1  result available
- out_ready  in  1  result consumed when high with out_valid
- out_data  out  ACCW  accumulated dot product
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: register act, weight, in_last; clear acc if in_first; plane counter b=0; go to RUN.
- RUN: each cycle partial = sum over i of act_i & {ABITS{weight_i[b]}}; acc <= acc + (partial << b); b++. After plane WBITS-1: in_last ? DONE : IDLE (acc retained).
- DONE: out_valid=1, out_data=acc. On out_ready go to IDLE; acc retained until the next in_first.
- partial width = ABITS + clog2(LANES); full-precision add, acc wraps modulo 2^ACCW (no saturation, no overflow flag).
- in_first=0 on the very first vector after reset accumulates onto 0.
- act/weight inputs are ignored outside the accepting cycle; registered copies hold through RUN.

## Timing
- Reset values: in_ready=0 while rst high, out_valid=0, out_data=0, busy=0, state IDLE, acc=0, b=0.
- Accept at cycle T; planes processed T+1..T+WBITS; out_valid first high at T+WBITS+1 (last vector).
- Non-last vector: in_ready high again at T+WBITS+1, giving back-to-back throughput of one vector per WBITS+1 cycles.
- out_valid/out_data held stable while out_ready=0; in_ready=0 during DONE.
- Handshake completes on the cycle out_valid&out_ready; in_ready=1 the following cycle.
- rst asserted mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and not emitted.

## Configuration
- BC_MAC_SIGNED_W_EN defined: weights are two's complement; plane WBITS-1 is subtracted (acc <= acc - (partial << (WBITS-1))); out_data is signed two's complement ACCW bits.
- Undefined: weights unsigned, every plane added; subtract path absent from the netlist.

## Structure
- Package bc_mac_pkg: state enum (IDLE/RUN/DONE), default parameter values, function computing partial width from LANES and ABITS.
- Sub-module bc_plane_sum: combinational AND gating plus compressor-tree reduction of one weight bit-plane to partial; parametrised by LANES and ABITS; no clock.
- Top holds the FSM, the plane counter, the operand registers and the accumulator.

## Test plan
- Reset: hold rst 3 cycles -> out_valid=0, out_data=0, busy=0, in_ready=0; after release in_ready=1 the next cycle.
- Max unsigned, macro off: all act=15, all weight=255, first=last=1 -> out_data=30600, out_valid exactly 9 cycles after accept.
- Accumulate: vector A act0=3, weight0=5, others 0, first=1, last=0; vector B act1=2, weight1=7, first=0, last=1 -> single result 29; no out_valid after A.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0; raise out_ready -> in_ready=1 one cycle later.
- Signed weight: act0=1, weight0=8'hFF, others 0 -> macro defined: out_data=24'hFFFFFF (-1); macro undefined: 255.
- Reset mid-RUN: assert rst during plane 3 of a vector with first=1, last=1 -> no out_valid; a following vector with first=0, act0=1, weight0=1, last=1 -> out_data=1.

Source files
------------

// File: rtl/bc_mac_pkg.sv
// bc_mac_pkg: shared definitions for the bit-column MAC engine.
//   - state_e        : FSM state encoding (idle / run / done)
//   - Def*           : default parameter values for LANES, ABITS, WBITS, ACCW
//   - partial_width(): width of one reduced bit-plane sum
package bc_mac_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefLanes = 8;
    localparam int unsigned DefAbits = 4;
    localparam int unsigned DefWbits = 8;
    localparam int unsigned DefAccw  = 24;

    // LANES activations of ABITS each, summed without loss.
    function automatic int unsigned partial_width(input int unsigned lanes,
                                                  input int unsigned abits);
        return abits + $clog2(lanes);
    endfunction

endpackage

// File: rtl/bc_mac_seq_if.sv
// bc_mac_seq_if: vector-in / result-out handshake bundle of bc_mac_seq.
//   in_valid/in_ready/in_first/in_last : vector handshake and framing
//   act    [LANES*ABITS] : lane i at act[i*ABITS +: ABITS]
//   weight [LANES*WBITS] : lane i at weight[i*WBITS +: WBITS]
//   out_valid/out_ready/out_data       : result handshake
//   busy                               : engine in run or done
// Modports: master = buffer/requantiser side, slave = MAC engine.
interface bc_mac_seq_if
    import bc_mac_pkg::*;
#(
    parameter int unsigned LANES = DefLanes,
    parameter int unsigned ABITS = DefAbits,
    parameter int unsigned WBITS = DefWbits,
    parameter int unsigned ACCW  = DefAccw
);

    logic                   in_valid;
    logic                   in_ready;
    logic                   in_first;
    logic                   in_last;
    logic [LANES*ABITS-1:0] act;
    logic [LANES*WBITS-1:0] weight;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACCW-1:0]        out_data;
    logic                   busy;

    modport master (
        output in_valid, in_first, in_last, act, weight, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_first, in_last, act, weight, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/bc_plane_sum.sv
// bc_plane_sum: combinational reduction of one weight bit-plane.
//   act     [LANES*ABITS] in  : activations, lane i at act[i*ABITS +: ABITS]
//   plane   [LANES]       in  : bit b of every lane's weight
//   partial [PW]          out : sum over i of act_i & {ABITS{plane[i]}}
// Lanes are padded to a power of two and summed in a balanced binary tree.
module bc_plane_sum
    import bc_mac_pkg::*;
#(
    parameter int unsigned LANES = DefLanes,
    parameter int unsigned ABITS = DefAbits
) (
    input  logic [LANES*ABITS-1:0]                  act,
    input  logic [LANES-1:0]                        plane,
    output logic [partial_width(LANES, ABITS)-1:0]  partial
);

    localparam int unsigned PW     = partial_width(LANES, ABITS);
    localparam int unsigned Leaves = 1 << $clog2(LANES);

    // Heap layout: node[0] is the root, leaves start at Leaves-1.
    logic [PW-1:0] node [2*Leaves-1];

    always_comb begin
        for (int i = 0; i < int'(Leaves); i++) begin
            if (i < int'(LANES)) begin
                node[int'(Leaves) - 1 + i] = PW'(act[i*ABITS +: ABITS] & {ABITS{plane[i]}});
            end else begin
                node[int'(Leaves) - 1 + i] = '0;
            end
        end
        for (int k = int'(Leaves) - 2; k >= 0; k--) begin
            node[k] = node[2*k+1] + node[2*k+2];
        end
        partial = node[0];
    end

endmodule

// File: rtl/bc_mac_seq.sv
// bc_mac_seq: bit-serial (over weight bits) dot-product engine.
//   clk  in : clock, rising edge
//   rst  in : asynchronous active-high reset
//   bus     : bc_mac_seq_if.slave (vector in, result out, busy)
// One vector is accepted in idle, then WBITS cycles each reduce one weight
// bit-plane and shift-accumulate it. in_first clears the accumulator before
// the vector, in_last parks the result in done until out_ready.
// Build option: BC_MAC_SIGNED_W_EN makes weights two's complement (the top
// plane is subtracted); otherwise weights are unsigned.
module bc_mac_seq
    import bc_mac_pkg::*;
#(
    parameter int unsigned LANES = DefLanes,
    parameter int unsigned ABITS = DefAbits,
    parameter int unsigned WBITS = DefWbits,
    parameter int unsigned ACCW  = DefAccw
) (
    input logic         clk,
    input logic         rst,
    bc_mac_seq_if.slave bus
);

    localparam int unsigned PW = partial_width(LANES, ABITS);
    localparam int unsigned BW = (WBITS > 1) ? $clog2(WBITS) : 1;

    localparam logic [1:0] Idle = 2'(StIdle);
    localparam logic [1:0] Run  = 2'(StRun);
    localparam logic [1:0] Done = 2'(StDone);

    logic [1:0]             state_q, state_d;
    logic [BW-1:0]          plane_q, plane_d;
    logic [LANES*ABITS-1:0] act_q, act_d;
    logic [LANES*WBITS-1:0] weight_q, weight_d;
    logic                   last_q, last_d;
    logic [ACCW-1:0]        acc_q, acc_d;

    logic [LANES-1:0] plane_bits;
    logic [PW-1:0]    partial;
    logic [ACCW-1:0]  shifted;
    logic             last_plane;

    always_comb begin
        plane_bits = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            plane_bits[i] = weight_q[i*WBITS + int'(plane_q)];
        end
    end

    bc_plane_sum #(
        .LANES (LANES),
        .ABITS (ABITS)
    ) u_plane_sum (
        .act     (act_q),
        .plane   (plane_bits),
        .partial (partial)
    );

    always_comb begin
        last_plane = (plane_q == BW'(WBITS - 1));
        shifted    = ACCW'(partial) << plane_q;

        state_d  = state_q;
        plane_d  = plane_q;
        act_d    = act_q;
        weight_d = weight_q;
        last_d   = last_q;
        acc_d    = acc_q;

        case (state_q)
            Idle: begin
                if (bus.in_valid) begin
                    act_d    = bus.act;
                    weight_d = bus.weight;
                    last_d   = bus.in_last;
                    plane_d  = '0;
                    state_d  = Run;
                    if (bus.in_first) begin
                        acc_d = '0;
                    end
                end
            end
            Run: begin
`ifdef BC_MAC_SIGNED_W_EN
                // Sign plane carries weight -2^(WBITS-1).
                if (last_plane) begin
                    acc_d = acc_q - shifted;
                end else begin
                    acc_d = acc_q + shifted;
                end
`else
                acc_d = acc_q + shifted;
`endif
                plane_d = plane_q + BW'(1);
                if (last_plane) begin
                    plane_d = '0;
                    state_d = last_q ? Done : Idle;
                end
            end
            Done: begin
                if (bus.out_ready) begin
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= Idle;
            plane_q  <= '0;
            act_q    <= '0;
            weight_q <= '0;
            last_q   <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            plane_q  <= plane_d;
            act_q    <= act_d;
            weight_q <= weight_d;
            last_q   <= last_d;
            acc_q    <= acc_d;
        end
    end

    // Reset forces idle, so in_ready is masked to stay low while rst is held.
    assign bus.in_ready  = (state_q == Idle) && !rst;
    assign bus.out_valid = (state_q == Done);
    assign bus.out_data  = acc_q;
    assign bus.busy      = (state_q == Run) || (state_q == Done);

endmodule

// File: tb/tb_bc_mac_seq.sv
module tb_bc_mac_seq;
    import bc_mac_pkg::*;

    localparam int unsigned LANES = 8;
    localparam int unsigned ABITS = 4;
    localparam int unsigned WBITS = 8;
    localparam int unsigned ACCW  = 24;

`ifdef BC_MAC_SIGNED_W_EN
    localparam logic [ACCW-1:0] ExpMax = 24'hFFFF88; // 8 * 15 * -1
    localparam logic [ACCW-1:0] ExpSgn = 24'hFFFFFF; // 1 * -1
`else
    localparam logic [ACCW-1:0] ExpMax = 24'd30600;  // 8 * 15 * 255
    localparam logic [ACCW-1:0] ExpSgn = 24'd255;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bc_mac_seq_if #(.LANES(LANES), .ABITS(ABITS), .WBITS(WBITS), .ACCW(ACCW)) bus ();

    bc_mac_seq #(.LANES(LANES), .ABITS(ABITS), .WBITS(WBITS), .ACCW(ACCW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [ACCW-1:0] data;
        int              due;
    } exp_t;

    exp_t            exp_q[$];
    logic [ACCW-1:0] model_acc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Dot product straight from the arithmetic definition, wrapped to ACCW.
    function automatic logic [ACCW-1:0] dot(input logic [LANES*ABITS-1:0] a,
                                            input logic [LANES*WBITS-1:0] w);
        longint s = 0;
        for (int i = 0; i < int'(LANES); i++) begin
            longint av = longint'(a[i*ABITS +: ABITS]);
            longint wv = longint'(w[i*WBITS +: WBITS]);
`ifdef BC_MAC_SIGNED_W_EN
            if (w[i*WBITS + WBITS - 1]) wv = wv - (longint'(1) << WBITS);
`endif
            s = s + av * wv;
        end
        return s[ACCW-1:0];
    endfunction

    // Offer a vector at a negedge, wait (bounded) for acceptance, update the model.
    task automatic send(input logic [LANES*ABITS-1:0] a, input logic [LANES*WBITS-1:0] w,
                        input bit first, input bit last, output int acc_cyc);
        int waited = 0;
        acc_cyc = cyc;
        bus.act      = a;
        bus.weight   = w;
        bus.in_first = first;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_in_time", bus.in_ready, 1);
        if (bus.in_ready) begin
            if (first) model_acc = '0;
            model_acc = model_acc + dot(a, w);
            if (last) exp_q.push_back('{data: model_acc, due: cyc + int'(WBITS) + 1});
            acc_cyc = cyc;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.act      = $urandom;
        bus.weight   = {$urandom, $urandom};
        bus.in_first = 1'($urandom_range(0, 1));
        bus.in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.out_valid, 1);
    endtask

    // Per-cycle comparison against the model queue.
    initial begin
        logic exp_ov;
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b0) begin
                exp_ov = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
                check("out_valid", bus.out_valid, exp_ov);
                if (bus.out_valid && exp_q.size() > 0) begin
                    check("out_data", bus.out_data, exp_q[0].data);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES*ABITS-1:0] a;
        logic [LANES*WBITS-1:0] w;
        int c;
        int n;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.act       = '0;
        bus.weight    = '0;
        bus.out_ready = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);

        // Full-scale operands; result exactly WBITS+1 cycles after accept.
        send('1, '1, 1'b1, 1'b1, c);
        while (cyc < c + int'(WBITS)) @(negedge clk);
        check("max_valid_early", bus.out_valid, 0);
        @(negedge clk);
        check("max_valid_latency", bus.out_valid, 1);
        check("max_data", bus.out_data, ExpMax);
        @(negedge clk);

        // Two-vector accumulation with a single result.
        a = '0; w = '0; a[3:0] = 4'd3; w[7:0] = 8'd5;
        send(a, w, 1'b1, 1'b0, c);
        a = '0; w = '0; a[7:4] = 4'd2; w[15:8] = 8'd7;
        send(a, w, 1'b0, 1'b1, c);
        wait_valid("acc_valid");
        check("acc_data", bus.out_data, 29);
        @(negedge clk);

        // Top weight bit set, held under backpressure.
        bus.out_ready = 1'b0;
        a = '0; w = '0; a[3:0] = 4'd1; w[7:0] = 8'hFF;
        send(a, w, 1'b1, 1'b1, c);
        wait_valid("bp_valid");
        check("sgn_data", bus.out_data, ExpSgn);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid_hold", bus.out_valid, 1);
            check("bp_data_hold", bus.out_data, ExpSgn);
            check("bp_in_ready_low", bus.in_ready, 0);
            check("bp_busy", bus.busy, 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_valid", bus.out_valid, 0);

        // Reset during plane 3 discards the result and the accumulator.
        send('1, {$urandom, $urandom}, 1'b1, 1'b1, c);
        while (cyc < c + 4) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_acc = '0;
        #1;
        check("midrun_rst_busy", bus.busy, 0);
        check("midrun_rst_valid", bus.out_valid, 0);
        check("midrun_rst_data", bus.out_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a = '0; w = '0; a[3:0] = 4'd1; w[7:0] = 8'd1;
        send(a, w, 1'b0, 1'b1, c);
        wait_valid("midrun_next_valid");
        check("midrun_next_data", bus.out_data, 1);
        @(negedge clk);

        // Randomised vectors with random framing and backpressure.
        rand_ready = 1'b1;
        for (int v = 0; v < 40; v++) begin
            a = $urandom;
            w = {$urandom, $urandom};
            send(a, w, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), c);
        end
        send($urandom, {$urandom, $urandom}, 1'b0, 1'b1, c);
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_results", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
